extmem_dma: RTL and testbench
=============================

Name: extmem_dma

Overview:
- Word-granular DMA engine between the external-memory port and the on-chip tile RAMs (FMI, KEX, KPW, KDW, FMO) of inverted_residual_block.
- Load mode moves `len` words from external memory into a local RAM.
- Store mode streams `len` words from a local RAM out to external memory, used for FMO write-back.
- Its external side is the request/valid/write port that the system memory model services; completion is reported on `finish`, which drives finish_dma.

Parameters:
- ADDR_W, 32, external word-address width
- DATA_W, 32, external and local data width
- LADDR_W, 12, local RAM address width
- LEN_W, 16, transfer length width (in words)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  one-cycle command strobe; sampled only in IDLE
- dir  in  1  0 = load (ext->local), 1 = store (local->ext)
- ext_base  in  ADDR_W  first external word address
- loc_base  in  LADDR_W  first local word address
- len  in  LEN_W  number of words to transfer; 0 is legal
- busy  out  1  high from the cycle after an accepted start until finish
- finish  out  1  one-cycle completion pulse
- request_extmem  out  1  one-cycle read-request pulse
- write_extmem  out  1  one-cycle write pulse
- addr_extmem  out  ADDR_W  external address
- w_data  out  DATA_W  external write data
- valid_extmem  in  1  read data valid
- data_extmem  in  DATA_W  read data
- ram_we  out  1  local RAM write enable
- ram_re  out  1  local RAM read enable
- ram_addr  out  LADDR_W  local RAM address
- ram_wdata  out  DATA_W  local RAM write data
- ram_rdata  in  DATA_W  local RAM read data, 1-cycle latency after ram_re

Behaviour:
- Reset (rst=0 at a clock edge):
  - State returns to IDLE and all counters clear.
  - Every output is driven to 0.
  - No finish pulse is issued, including when reset arrives mid-transfer.
  - A valid_extmem still in flight after reset is ignored.
- FSM states: IDLE, LD_REQ, LD_WAIT, LD_WR, ST_STREAM, ST_DRAIN, DONE.
- IDLE:
  - start=1 latches ext_base, loc_base, len and dir; word index i is cleared.
  - len=0 -> go to DONE.
  - dir=0 -> go to LD_REQ; dir=1 -> go to ST_STREAM.
  - start while not in IDLE is ignored.
- Addressing:
  - External address is ext_base+i, truncated to ADDR_W.
  - Local address is loc_base+i mod 2^LADDR_W; local addresses wrap silently.
- LD_REQ:
  - Drive request_extmem=1 for exactly one cycle, with addr_extmem=ext_base+i.
  - Go to LD_WAIT.
- LD_WAIT:
  - addr_extmem is held stable.
  - Wait indefinitely for valid_extmem; there is no timeout.
  - On valid_extmem, register data_extmem and go to LD_WR.
  - valid_extmem in any other state is ignored.
- LD_WR:
  - ram_we=1, ram_addr=loc_base+i, ram_wdata = captured word.
  - Increment i; if i now equals len, go to DONE, otherwise go to LD_REQ.
  - Against a 2-cycle-latency memory, throughput is one word per 4 cycles.
- ST_STREAM:
  - Each cycle: ram_re=1 for word i, and write_extmem=1 for word i-1 when i>0.
  - write_extmem uses addr_extmem=ext_base+(i-1) and w_data=ram_rdata.
  - After the read for word len-1, go to ST_DRAIN.
- ST_DRAIN: write word len-1, then go to DONE. Writes are posted and never acknowledged.
- Store throughput is 1 word per cycle; total store occupancy is len+1 cycles.
- DONE: finish=1 for one cycle, busy=0, then go to IDLE.
- A start accepted in the same cycle that DONE returns to IDLE is honoured, since FSM is already IDLE for that cycle.
- request_extmem and write_extmem are never asserted in the same cycle.

Decomposition:
- Package dma_pkg holds:
  - the state enum dma_state_t;
  - DIR_LOAD=0 and DIR_STORE=1;
  - region base constants OFFSET_INF_CONV=0, OFFSET_FMI=2*2^20, OFFSET_FMO=4*2^20, OFFSET_KEX=6*2^20, OFFSET_KPW=26*2^20, OFFSET_KDW=44*2^20.
- One natural sub-module, dma_addr_gen: the word counter and the external/local address adders, with wrap and termination compare.

Test Plan:
- Load, len=4, ext_base=OFFSET_FMI, loc_base=0, memory model with 2-cycle latency returning 0xA0..0xA3:
  - RAM writes 0xA0..0xA3 land at addresses 0..3;
  - four request pulses at 0x200000..0x200003;
  - finish exactly one cycle after the last ram_we.
- Store, len=3, loc_base=8 holding 0x11, 0x22, 0x33, ext_base=OFFSET_FMO:
  - write_extmem on 3 consecutive cycles to 0x400000..0x400002 with those data;
  - finish in the next cycle.
- len=0 with start: finish two cycles after start, with no request, write or ram_* activity.
- Second start pulse during a load of len=2: ignored; exactly 2 requests are issued and one finish.
- Local wrap: load len=4 with loc_base=4094 -> ram_addr sequence 4094, 4095, 0, 1.
- Reset during LD_WAIT, then a late valid_extmem:
  - all outputs are 0 and no finish pulse occurs;
  - a new load of len=1 completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and memory-map constants for extmem_dma
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_REQ    = 3'd1,
        LD_WAIT   = 3'd2,
        LD_WR     = 3'd3,
        ST_STREAM = 3'd4,
        ST_DRAIN  = 3'd5,
        DONE      = 3'd6
    } dma_state_t;

    localparam logic DIR_LOAD  = 1'b0;
    localparam logic DIR_STORE = 1'b1;

    // External word-address region bases of the inverted_residual_block image
    localparam logic [31:0] OFFSET_INF_CONV = 32'd0;
    localparam logic [31:0] OFFSET_FMI      = 32'd2  * 32'd1048576;
    localparam logic [31:0] OFFSET_FMO      = 32'd4  * 32'd1048576;
    localparam logic [31:0] OFFSET_KEX      = 32'd6  * 32'd1048576;
    localparam logic [31:0] OFFSET_KPW      = 32'd26 * 32'd1048576;
    localparam logic [31:0] OFFSET_KDW      = 32'd44 * 32'd1048576;

endpackage

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - word counter, external/local address adders and end-of-transfer compare
module dma_addr_gen #(
    parameter int ADDR_W  = 32,
    parameter int LADDR_W = 12,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               inc_i,
    input  logic [ADDR_W-1:0]  ext_base_i,
    input  logic [LADDR_W-1:0] loc_base_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic [ADDR_W-1:0]  ext_prev_o,
    output logic [ADDR_W-1:0]  ext_next_o,
    output logic [LADDR_W-1:0] loc_addr_o,
    output logic               first_o,
    output logic               last_o
);

    logic [ADDR_W-1:0]  ext_base_q;
    logic [LADDR_W-1:0] loc_base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_base_q <= '0;
            loc_base_q <= '0;
            len_q      <= '0;
            idx_q      <= '0;
        end else if (load_i) begin
            ext_base_q <= ext_base_i;
            loc_base_q <= loc_base_i;
            len_q      <= len_i;
            idx_q      <= '0;
        end else if (inc_i) begin
            idx_q <= idx_q + LEN_W'(1);
        end
    end

    // Both adders truncate to their port width, so addresses wrap silently
    assign ext_prev_o = ext_base_q + ADDR_W'(idx_q) - ADDR_W'(1);
    assign ext_next_o = ext_base_q + ADDR_W'(idx_q) + ADDR_W'(1);
    assign loc_addr_o = loc_base_q + LADDR_W'(idx_q);
    assign first_o    = (idx_q == '0);
    assign last_o     = ((idx_q + LEN_W'(1)) == len_q);

endmodule

// File: rtl/extmem_dma.sv
// rtl/extmem_dma.sv - word-granular DMA between the external-memory port and the tile RAMs
module extmem_dma
    import dma_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LADDR_W = 12,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir,
    input  logic [ADDR_W-1:0]  ext_base,
    input  logic [LADDR_W-1:0] loc_base,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               finish,
    output logic               request_extmem,
    output logic               write_extmem,
    output logic [ADDR_W-1:0]  addr_extmem,
    output logic [DATA_W-1:0]  w_data,
    input  logic               valid_extmem,
    input  logic [DATA_W-1:0]  data_extmem,
    output logic               ram_we,
    output logic               ram_re,
    output logic [LADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata
);

    dma_state_t         state_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               busy_q, finish_q, request_q, write_q, ram_we_q, ram_re_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0]  ram_wdata_q;

    logic               load_cmd, inc_idx, first, last;
    logic [ADDR_W-1:0]  ext_prev, ext_next;
    logic [LADDR_W-1:0] loc_addr;

    assign load_cmd = (state_q == IDLE) && start;
    assign inc_idx  = (state_q == LD_WR) || (state_q == ST_STREAM);

    dma_addr_gen #(
        .ADDR_W  (ADDR_W),
        .LADDR_W (LADDR_W),
        .LEN_W   (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_cmd),
        .inc_i      (inc_idx),
        .ext_base_i (ext_base),
        .loc_base_i (loc_base),
        .len_i      (len),
        .ext_prev_o (ext_prev),
        .ext_next_o (ext_next),
        .loc_addr_o (loc_addr),
        .first_o    (first),
        .last_o     (last)
    );

    // Request pulses are issued on entry to LD_REQ to keep the load loop at four cycles;
    // all other strobes trail their state by one cycle, lining up with the RAM read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            request_q   <= 1'b0;
            write_q     <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            addr_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            finish_q  <= 1'b0;
            request_q <= 1'b0;
            write_q   <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_re_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            state_q <= DONE;
                        end else if (dir == DIR_LOAD) begin
                            state_q   <= LD_REQ;
                            request_q <= 1'b1;
                            addr_q    <= ext_base;
                        end else begin
                            state_q <= ST_STREAM;
                        end
                    end
                end
                LD_REQ: state_q <= LD_WAIT;
                LD_WAIT: begin
                    if (valid_extmem) begin
                        rd_data_q <= data_extmem;
                        state_q   <= LD_WR;
                    end
                end
                LD_WR: begin
                    ram_we_q    <= 1'b1;
                    ram_addr_q  <= loc_addr;
                    ram_wdata_q <= rd_data_q;
                    if (last) begin
                        state_q <= DONE;
                    end else begin
                        state_q   <= LD_REQ;
                        request_q <= 1'b1;
                        addr_q    <= ext_next;
                    end
                end
                ST_STREAM: begin
                    ram_re_q   <= 1'b1;
                    ram_addr_q <= loc_addr;
                    if (!first) begin
                        write_q <= 1'b1;
                        addr_q  <= ext_prev;
                    end
                    if (last) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    write_q <= 1'b1;
                    addr_q  <= ext_prev;
                    state_q <= DONE;
                end
                DONE: begin
                    finish_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign finish         = finish_q;
    assign request_extmem = request_q;
    assign write_extmem   = write_q;
    assign addr_extmem    = addr_q;
    assign w_data         = write_q ? ram_rdata : '0;
    assign ram_we         = ram_we_q;
    assign ram_re         = ram_re_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;

endmodule

// File: tb/tb_extmem_dma.sv
// tb/tb_extmem_dma.sv - randomized self-checking bench for extmem_dma
module tb_extmem_dma;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, dir;
    logic [31:0] ext_base;
    logic [11:0] loc_base;
    logic [15:0] len;
    logic        busy, finish, request_extmem, write_extmem;
    logic [31:0] addr_extmem, w_data;
    logic        valid_extmem = 1'b0;
    logic [31:0] data_extmem = '0;
    logic        ram_we, ram_re;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    extmem_dma dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir),
        .ext_base(ext_base), .loc_base(loc_base), .len(len),
        .busy(busy), .finish(finish),
        .request_extmem(request_extmem), .write_extmem(write_extmem),
        .addr_extmem(addr_extmem), .w_data(w_data),
        .valid_extmem(valid_extmem), .data_extmem(data_extmem),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Local tile RAM: synchronous, one-cycle read latency
    logic [31:0] lram [4096];
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= lram[ram_addr];
        if (ram_we) lram[ram_addr] = ram_wdata;
    end

    // External memory: a read returns mem_lat cycles after its request
    logic [31:0] xmem [logic [31:0]];
    function automatic logic [31:0] ext_rd(input logic [31:0] a);
        if (xmem.exists(a)) return xmem[a];
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    int          mem_lat = 2;
    int          pend_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    always @(posedge clk) begin
        valid_extmem <= 1'b0;
        data_extmem  <= $urandom;
        if (request_extmem) begin
            pend      <= 1'b1;
            pend_cnt  <= mem_lat - 1;
            pend_addr <= addr_extmem;
        end else if (pend) begin
            if (pend_cnt == 1) begin
                valid_extmem <= 1'b1;
                data_extmem  <= ext_rd(pend_addr);
                pend         <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t req_q[$], ramw_q[$], extw_q[$];
    int  fin_q[$];
    int  busy_n = 0, re_n = 0, overlap_n = 0;

    always @(negedge clk) begin
        if (request_extmem) req_q.push_back('{cyc, addr_extmem, 32'd0});
        if (ram_we)         ramw_q.push_back('{cyc, {20'd0, ram_addr}, ram_wdata});
        if (write_extmem)   extw_q.push_back('{cyc, addr_extmem, w_data});
        if (finish)         fin_q.push_back(cyc);
        if (busy)           busy_n++;
        if (ram_re)         re_n++;
        if (request_extmem && write_extmem) overlap_n++;
    end

    function automatic logic any_output();
        return |{busy, finish, request_extmem, write_extmem, addr_extmem, w_data,
                 ram_we, ram_re, ram_addr, ram_wdata};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        req_q.delete();
        ramw_q.delete();
        extw_q.delete();
        fin_q.delete();
        busy_n = 0;
        re_n   = 0;
    endtask

    task automatic run_xfer(input logic d, input logic [31:0] eb, input logic [11:0] lb,
                            input logic [15:0] ln, input int lat, input bit dup);
        int          s, exp_fin, bound, la, per;
        logic [31:0] ea;
        mem_lat = lat;
        clear_log();
        dir = d; ext_base = eb; loc_base = lb; len = ln; start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        // Scramble the command inputs: the engine must work from its latched copy
        dir = 1'($urandom); ext_base = $urandom; loc_base = 12'($urandom); len = 16'($urandom);
        if (dup) begin
            tick();
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        bound = int'(ln) * (lat + 3) + 20;
        for (int t = 0; t < bound && fin_q.size() == 0; t++) tick();
        repeat (4) tick();

        per = lat + 2;
        if (d == DIR_LOAD || ln == 0) exp_fin = s + 2 + int'(ln) * per;
        else                          exp_fin = s + int'(ln) + 3;

        check("finish_count", fin_q.size(), 1);
        if (fin_q.size() > 0) check("finish_cycle", fin_q[0], exp_fin);
        check("busy_cycles", busy_n, exp_fin - s - 1);

        if (d == DIR_LOAD) begin
            check("req_count", req_q.size(), ln);
            check("ramw_count", ramw_q.size(), ln);
            check("ld_extw_count", extw_q.size(), 0);
            for (int k = 0; k < int'(ln) && k < req_q.size(); k++) begin
                ea = eb + k;
                check("req_addr", req_q[k].a, ea);
                check("req_cycle", req_q[k].cyc, s + 1 + k * per);
            end
            for (int k = 0; k < int'(ln) && k < ramw_q.size(); k++) begin
                ea = eb + k;
                la = (int'(lb) + k) % 4096;
                check("ramw_addr", ramw_q[k].a, la);
                check("ramw_data", ramw_q[k].d, ext_rd(ea));
                check("ramw_cycle", ramw_q[k].cyc, s + 1 + (k + 1) * per);
            end
        end else begin
            check("st_req_count", req_q.size(), 0);
            check("st_ramw_count", ramw_q.size(), 0);
            check("ram_re_count", re_n, ln);
            check("extw_count", extw_q.size(), ln);
            for (int k = 0; k < int'(ln) && k < extw_q.size(); k++) begin
                ea = eb + k;
                la = (int'(lb) + k) % 4096;
                check("extw_addr", extw_q[k].a, ea);
                check("extw_data", extw_q[k].d, lram[la]);
                check("extw_cycle", extw_q[k].cyc, s + 3 + k);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic        rd;
        logic [15:0] rl;
        rst = 1'b0; start = 1'b0; dir = 1'b0; ext_base = '0; loc_base = '0; len = '0;
        for (int i = 0; i < 4096; i++) lram[i] = $urandom;
        repeat (3) tick();
        check("reset_outputs", any_output(), 0);
        rst = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) xmem[OFFSET_FMI + k] = 32'hA0 + k;
        run_xfer(DIR_LOAD, OFFSET_FMI, 12'd0, 16'd4, 2, 1'b0);

        lram[8] = 32'h11; lram[9] = 32'h22; lram[10] = 32'h33;
        run_xfer(DIR_STORE, OFFSET_FMO, 12'd8, 16'd3, 2, 1'b0);

        run_xfer(DIR_LOAD, OFFSET_KEX, 12'd50, 16'd0, 2, 1'b0);
        run_xfer(DIR_LOAD, OFFSET_KEX, 12'd100, 16'd2, 2, 1'b1);
        run_xfer(DIR_LOAD, OFFSET_KPW, 12'd4094, 16'd4, 2, 1'b0);

        // Reset while waiting on a read; the late response must be ignored
        mem_lat = 4;
        clear_log();
        dir = DIR_LOAD; ext_base = OFFSET_KDW; loc_base = 12'd0; len = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 20 && req_q.size() == 0; t++) tick();
        check("rst_test_req_seen", req_q.size(), 1);
        tick();
        rst = 1'b0;
        tick();
        check("mid_reset_outputs", any_output(), 0);
        rst = 1'b1;
        clear_log();
        repeat (10) tick();
        check("rst_no_finish", fin_q.size(), 0);
        check("rst_no_activity", req_q.size() + ramw_q.size() + extw_q.size(), 0);
        run_xfer(DIR_LOAD, OFFSET_KDW + 32'd5, 12'd7, 16'd1, 2, 1'b0);

        for (int n = 0; n < 24; n++) begin
            rd = 1'($urandom_range(0, 1));
            rl = 16'($urandom_range(0, 6));
            run_xfer(rd, $urandom, 12'($urandom_range(0, 4095)), rl,
                     $urandom_range(2, 5), ($urandom_range(0, 3) == 0) && (rl >= 2));
        end

        check("no_req_write_overlap", overlap_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
